// File: rtl/issue_rx_pkg.sv
// Shared types and constants for the issue receiver.
package issue_rx_pkg;
  typedef enum logic {RX_IDLE, RX_ARMED} rx_state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/issue_receiver_if.sv
// Issuer-side handshake and execute-side valid/ready stream of the issue receiver.
interface issue_receiver_if #(parameter int WIDTH = 32);
  logic             trigger_in;
  logic             ready_in;
  logic [WIDTH-1:0] data_in;
  logic             rx_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    input  trigger_in, ready_in, data_in, out_ready,
    output rx_ready, out_valid, out_data
  );

  modport slave (
    output trigger_in, ready_in, data_in, out_ready,
    input  rx_ready, out_valid, out_data
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO using read/write pointers with an extra wrap bit.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && !empty;
  // Head reads zero when empty so the output is defined straight out of reset.
  assign rdata  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/issue_receiver.sv
// Receives the issuer's two-phase trigger/ready handshake, queues passed words
// and counts squashed issues.
module issue_receiver
  import issue_rx_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  issue_receiver_if.master  bus,
  output logic [CNT_W-1:0]  squash_cnt,
  output logic              overflow,
  output logic              protocol_err,
  input  logic              clear_status
);
  logic [SYNC_STAGES:0] trig_sync;
  logic [SYNC_STAGES:0] rdy_sync;
  logic                 tog;
  logic                 rise;
  rx_state_t            state;
  rx_state_t            state_nxt;
  logic                 capture;
  logic                 squash_evt;
  logic                 perr_evt;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 push;
  logic                 ovf_evt;
  logic                 rx_ready_q;
  logic [CNT_W-1:0]     squash_base;

  // Two synchroniser flops plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_sync <= '0;
      rdy_sync  <= '0;
    end else begin
      trig_sync <= {trig_sync[SYNC_STAGES-1:0], bus.trigger_in};
      rdy_sync  <= {rdy_sync[SYNC_STAGES-1:0], bus.ready_in};
    end
  end

  assign tog  = trig_sync[SYNC_STAGES-1] ^ trig_sync[SYNC_STAGES];
  assign rise = rdy_sync[SYNC_STAGES-1] & ~rdy_sync[SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (tog && !rise) state_nxt = RX_ARMED;
      RX_ARMED: if (rise)         state_nxt = RX_IDLE;
      default:                    state_nxt = RX_IDLE;
    endcase
  end

  // An ARMED toggle means the previous issue never got its ready pulse.
  always_comb begin
    capture    = 1'b0;
    squash_evt = 1'b0;
    perr_evt   = 1'b0;
    case (state)
      RX_IDLE: begin
        capture  = rise && tog;
        perr_evt = rise && !tog;
      end
      RX_ARMED: begin
        capture    = rise;
        squash_evt = tog;
      end
      default: ;
    endcase
  end

  assign pop     = !empty && bus.out_ready;
  assign push    = capture && (!full || pop);
  assign ovf_evt = capture && full && !pop;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (bus.data_in),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .rdata (bus.out_data)
  );

  assign bus.out_valid = !empty;
  assign bus.rx_ready  = rx_ready_q;

  // Clear drops the old value; an event in the same cycle lands on top of it.
  assign squash_base = clear_status ? '0 : squash_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      squash_cnt   <= '0;
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
      rx_ready_q   <= 1'b1;
    end else begin
      squash_cnt   <= (squash_evt && squash_base != '1) ? squash_base + CNT_W'(1) : squash_base;
      overflow     <= (overflow && !clear_status) || ovf_evt;
      protocol_err <= (protocol_err && !clear_status) || perr_evt;
      rx_ready_q   <= !full;
    end
  end
endmodule
